// File: rtl/dense_layer_seq_pkg.sv
// Shared fixed-point definitions for the dense layer: format defaults,
// saturation limits, accumulator width rule and FSM encoding.
package fixed_point_pkg;

    localparam int BITSIZE_DEF   = 16;
    localparam int FRAC_BITS_DEF = 8;

    localparam logic signed [BITSIZE_DEF-1:0] SAT_MAX =
        {1'b0, {(BITSIZE_DEF-1){1'b1}}};
    localparam logic signed [BITSIZE_DEF-1:0] SAT_MIN =
        {1'b1, {(BITSIZE_DEF-1){1'b0}}};

    // Full product width plus enough headroom for N_IN terms and the bias.
    function automatic int acc_w(input int bits, input int n_in);
        return 2 * bits + $clog2(n_in + 1) + 1;
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/dense_layer_seq_if.sv
// Start/done handshake plus the x/w/b operand buses and y result bus
// of one dense layer; master drives operands, slave returns results.
interface dense_layer_seq_if
    import fixed_point_pkg::*;
#(
    parameter int BITSIZE = BITSIZE_DEF,
    parameter int N_IN    = 10,
    parameter int N_OUT   = 6
);
    logic                          start;
    logic [BITSIZE*N_IN-1:0]       x;
    logic [BITSIZE*N_IN*N_OUT-1:0] w;
    logic [BITSIZE*N_OUT-1:0]      b;
    logic [BITSIZE*N_OUT-1:0]      y;
    logic                          busy;
    logic                          done;

    modport master (
        output start, x, w, b,
        input  y, busy, done
    );

    modport slave (
        input  start, x, w, b,
        output y, busy, done
    );
endinterface

// File: rtl/dense_layer_seq_mac_lane.sv
// One output lane: bias load, full-precision MAC, shift/saturate (and
// optional ReLU when DENSE_LAYER_RELU_EN is defined) into a registered y.
module dense_mac_lane
    import fixed_point_pkg::*;
#(
    parameter int BITSIZE   = BITSIZE_DEF,
    parameter int FRAC_BITS = FRAC_BITS_DEF,
    parameter int N_IN      = 10
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load,
    input  logic                      en,
    input  logic                      last,
    input  logic signed [BITSIZE-1:0] bias,
    input  logic signed [BITSIZE-1:0] x_el,
    input  logic signed [BITSIZE-1:0] w_el,
    output logic        [BITSIZE-1:0] y
);
    localparam int AW = acc_w(BITSIZE, N_IN);

    localparam logic signed [AW-1:0] LIM_HI =
        {{(AW-BITSIZE+1){1'b0}}, {(BITSIZE-1){1'b1}}};
    localparam logic signed [AW-1:0] LIM_LO =
        {{(AW-BITSIZE+1){1'b1}}, {(BITSIZE-1){1'b0}}};

    logic signed [2*BITSIZE-1:0] prod;
    logic signed [AW-1:0]        acc;
    logic signed [AW-1:0]        acc_nxt;
    logic signed [AW-1:0]        shifted;
    logic        [BITSIZE-1:0]   y_nxt;

    assign prod    = x_el * w_el;
    assign acc_nxt = acc + AW'(prod);
    assign shifted = acc_nxt >>> FRAC_BITS;

    // Clamp the rescaled sum into the output format, then apply ReLU.
    always_comb begin
        y_nxt = shifted[BITSIZE-1:0];
        if (shifted > LIM_HI) begin
            y_nxt = LIM_HI[BITSIZE-1:0];
        end else if (shifted < LIM_LO) begin
            y_nxt = LIM_LO[BITSIZE-1:0];
        end
`ifdef DENSE_LAYER_RELU_EN
        if (y_nxt[BITSIZE-1]) begin
            y_nxt = '0;
        end
`endif
    end

    // Accumulator seeds with the scaled bias and registers y on the last term.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
            y   <= '0;
        end else if (load) begin
            acc <= AW'(bias) <<< FRAC_BITS;
        end else if (en) begin
            acc <= acc_nxt;
            if (last) begin
                y <= y_nxt;
            end
        end
    end

endmodule

// File: rtl/dense_layer_seq.sv
// Sequential fully-connected layer y = W^T x + b, one x element per cycle.
// Optional ReLU on the outputs: define DENSE_LAYER_RELU_EN.
module dense_layer_seq
    import fixed_point_pkg::*;
#(
    parameter int BITSIZE     = BITSIZE_DEF,
    parameter int FRAC_BITS   = FRAC_BITS_DEF,
    parameter int N_IN        = 10,
    parameter int N_OUT       = 6,
    parameter int REVERSE_OUT = 1
) (
    input logic          clk,
    input logic          reset,
    dense_layer_seq_if.slave bus
);
    localparam int CW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [CW-1:0] J_LAST = CW'(N_IN - 1);

    state_t                     state;
    logic [CW-1:0]              j;
    logic                       accept;
    logic                       acc_en;
    logic                       last;
    logic signed [BITSIZE-1:0]  x_el;
    logic [BITSIZE*N_OUT-1:0]   y_all;

    assign accept = bus.start && (state == IDLE || state == DONE);
    assign acc_en = (state == ACCUM);
    assign last   = acc_en && (j == J_LAST);
    assign x_el   = bus.x[BITSIZE*j +: BITSIZE];
    assign bus.y  = y_all;

    // Control FSM with registered busy/done and the input index counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            j         <= '0;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        state    <= ACCUM;
                        j        <= '0;
                        bus.busy <= 1'b1;
                    end else begin
                        state    <= IDLE;
                    end
                end
                ACCUM: begin
                    if (j == J_LAST) begin
                        state    <= DONE;
                        j        <= '0;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                    end else begin
                        j        <= j + CW'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                end
            endcase
        end
    end

    for (genvar k = 0; k < N_OUT; k++) begin : g_lane
        localparam int SLOT = (REVERSE_OUT != 0) ? (N_OUT - 1 - k) : k;
        logic [BITSIZE-1:0] y_k;

        dense_mac_lane #(
            .BITSIZE   (BITSIZE),
            .FRAC_BITS (FRAC_BITS),
            .N_IN      (N_IN)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .load  (accept),
            .en    (acc_en),
            .last  (last),
            .bias  (bus.b[BITSIZE*k +: BITSIZE]),
            .x_el  (x_el),
            .w_el  (bus.w[BITSIZE*N_OUT*j + BITSIZE*k +: BITSIZE]),
            .y     (y_k)
        );

        assign y_all[BITSIZE*SLOT +: BITSIZE] = y_k;
    end

endmodule

// File: tb/tb_dense_layer_seq.sv
// Directed bench for dense_layer_seq: both output orderings side by side,
// checked every cycle against an arithmetic model plus literal results.
module tb_dense_layer_seq;
    import fixed_point_pkg::*;

    localparam int BS = 16;
    localparam int FB = 8;
    localparam int NI = 10;
    localparam int NO = 6;
    localparam int YW = BS * NO;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [BS*NI-1:0]    x = '0;
    logic [BS*NI*NO-1:0] w = '0;
    logic [BS*NO-1:0]    b = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dense_layer_seq_if #(.BITSIZE(BS), .N_IN(NI), .N_OUT(NO)) bus_r ();
    dense_layer_seq_if #(.BITSIZE(BS), .N_IN(NI), .N_OUT(NO)) bus_f ();

    assign bus_r.start = start;
    assign bus_r.x     = x;
    assign bus_r.w     = w;
    assign bus_r.b     = b;
    assign bus_f.start = start;
    assign bus_f.x     = x;
    assign bus_f.w     = w;
    assign bus_f.b     = b;

    dense_layer_seq #(
        .BITSIZE(BS), .FRAC_BITS(FB), .N_IN(NI), .N_OUT(NO), .REVERSE_OUT(1)
    ) dut_r (.clk(clk), .reset(rst), .bus(bus_r));

    dense_layer_seq #(
        .BITSIZE(BS), .FRAC_BITS(FB), .N_IN(NI), .N_OUT(NO), .REVERSE_OUT(0)
    ) dut_f (.clk(clk), .reset(rst), .bus(bus_f));

    task automatic check(input string name, input logic [YW-1:0] act,
                         input logic [YW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Plain-arithmetic evaluation of one output element.
    function automatic logic [BS-1:0] lane_val(input int k);
        longint s;
        s = longint'($signed(b[BS*k +: BS])) * (longint'(1) << FB);
        for (int jj = 0; jj < NI; jj++) begin
            s += longint'($signed(x[BS*jj +: BS]))
               * longint'($signed(w[BS*NO*jj + BS*k +: BS]));
        end
        s = s >>> FB;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
`ifdef DENSE_LAYER_RELU_EN
        if (s < 0) s = 0;
`endif
        return BS'(s);
    endfunction

    function automatic logic [YW-1:0] model_y(input bit rev);
        logic [YW-1:0] v;
        v = '0;
        for (int k = 0; k < NO; k++) begin
            if (rev) v[BS*(NO-1-k) +: BS] = lane_val(k);
            else     v[BS*k +: BS]        = lane_val(k);
        end
        return v;
    endfunction

    int            rem    = 0;
    logic          m_done = 1'b0;
    logic [YW-1:0] m_yr   = '0;
    logic [YW-1:0] m_yf   = '0;

    // Model: a run occupies NI busy cycles, then one done cycle with a new y.
    always @(posedge clk) begin
        if (rst) begin
            rem    <= 0;
            m_done <= 1'b0;
            m_yr   <= '0;
            m_yf   <= '0;
        end else if (rem == 0 && start) begin
            rem    <= NI;
            m_done <= 1'b0;
        end else if (rem == 1) begin
            rem    <= 0;
            m_done <= 1'b1;
            m_yr   <= model_y(1'b1);
            m_yf   <= model_y(1'b0);
        end else begin
            if (rem > 1) rem <= rem - 1;
            m_done <= 1'b0;
        end
    end

    // Every-cycle comparison of both DUTs against the model.
    always @(negedge clk) begin
        check("busy_r", YW'(bus_r.busy), YW'(rem != 0));
        check("busy_f", YW'(bus_f.busy), YW'(rem != 0));
        check("done_r", YW'(bus_r.done), YW'(m_done));
        check("done_f", YW'(bus_f.done), YW'(m_done));
        check("y_r", bus_r.y, m_yr);
        check("y_f", bus_f.y, m_yf);
    end

    task automatic set_all(input logic [BS-1:0] xv, input logic [BS-1:0] wv,
                           input logic [BS-1:0] bv);
        for (int i = 0; i < NI; i++) x[BS*i +: BS] = xv;
        for (int i = 0; i < NI*NO; i++) w[BS*i +: BS] = wv;
        for (int i = 0; i < NO; i++) b[BS*i +: BS] = bv;
    endtask

    task automatic run_once(output int lat, output int busy_n);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        busy_n = 0;
        while (!bus_r.done && lat < 40) begin
            if (bus_r.busy) busy_n++;
            @(negedge clk);
            lat++;
        end
        if (!bus_r.done) begin
            check("done_timeout", YW'(0), YW'(1));
        end
    endtask

    task automatic check_all(input string name, input logic [BS-1:0] v);
        check({name, "_r"}, bus_r.y, {NO{v}});
        check({name, "_f"}, bus_f.y, {NO{v}});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bn, nd, t1, t2;
        logic [BS-1:0] e_neg, e_sat_lo;
`ifdef DENSE_LAYER_RELU_EN
        e_neg    = 16'h0000;
        e_sat_lo = 16'h0000;
`else
        e_neg    = 16'hF680;
        e_sat_lo = 16'h8000;
`endif
        repeat (3) @(negedge clk);
        check("rst_y", bus_r.y, '0);
        check("rst_busy", YW'(bus_r.busy), '0);
        check("rst_done", YW'(bus_f.done), '0);
        rst = 1'b0;

        set_all(16'h0100, 16'h0100, 16'h0000);
        run_once(lat, bn);
        check("t1_latency", YW'(lat), YW'(11));
        check("t1_busy_cycles", YW'(bn), YW'(10));
        check_all("t1_y", 16'h0A00);

        set_all(16'h0100, 16'hFF00, 16'h0080);
        run_once(lat, bn);
        check_all("t2_y", e_neg);

        set_all(16'h7FFF, 16'h7FFF, 16'h7FFF);
        run_once(lat, bn);
        check_all("t3_sat_hi", 16'h7FFF);

        set_all(16'h7FFF, 16'h8000, 16'h7FFF);
        run_once(lat, bn);
        check_all("t3_sat_lo", e_sat_lo);

        set_all(16'h0000, 16'h0100, 16'h0000);
        for (int k = 0; k < NO; k++) b[BS*k +: BS] = 16'(16'h0600 - 16'h0100 * k);
        run_once(lat, bn);
        check("t4_rev_s0", YW'(bus_r.y[15:0]), YW'(16'h0100));
        check("t4_rev_s5", YW'(bus_r.y[95:80]), YW'(16'h0600));
        check("t4_fwd_s0", YW'(bus_f.y[15:0]), YW'(16'h0600));
        check("t4_fwd_s5", YW'(bus_f.y[95:80]), YW'(16'h0100));

        set_all(16'h0100, 16'h0100, 16'h0000);
        @(negedge clk);
        start = 1'b1;
        nd = 0;
        t1 = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            start = (c == 4);
            if (bus_r.done) begin
                nd++;
                if (nd == 1) t1 = c;
            end
        end
        check("t5_ignored_count", YW'(nd), YW'(1));
        check("t5_ignored_lat", YW'(t1), YW'(11));

        @(negedge clk);
        start = 1'b1;
        nd = 0;
        t1 = 0;
        t2 = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (bus_r.done) begin
                nd++;
                if (nd == 1) t1 = c;
                if (nd == 2) t2 = c;
            end
        end
        start = 1'b0;
        check("t5_b2b_count", YW'(nd), YW'(2));
        check("t5_b2b_gap", YW'(t2 - t1), YW'(11));
        check_all("t5_b2b_y", 16'h0A00);
        repeat (15) @(negedge clk);

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t6_busy", YW'(bus_r.busy), '0);
        check("t6_done", YW'(bus_r.done), '0);
        check_all("t6_y", 16'h0000);
        rst = 1'b0;
        nd = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus_r.done || bus_f.done) nd++;
        end
        check("t6_no_done", YW'(nd), '0);

        run_once(lat, bn);
        check("t6_rerun_lat", YW'(lat), YW'(11));
        check_all("t6_rerun_y", 16'h0A00);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
